lm_sm_sequencer: RTL and testbench
==================================

Name: lm_sm_sequencer

Overview:
- Multi-cycle controller that sequences the 8x16 register file and the memory port for the load-multiple (LM) and store-multiple (SM) instructions.
- Walks an 8-bit register mask from lowest to highest set bit.
- SM: reads each selected register and writes it to memory.
- LM: reads memory and writes each selected register.
- Memory addresses start at a base and increment by one per register transferred.
- Sits between the main control FSM and the register-file/memory ports; the main FSM hands over with start and waits for done.

Parameters:
NREG, 8, number of architectural registers (mask width)
AW, 3, register index width
DW, 16, data and memory address width

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin sequence; sampled only in IDLE
op_lm  in  1  1 = LM (mem->regs), 0 = SM (regs->mem); latched on start
imm_mask  in  NREG  register select mask; bit i selects Ri; latched on start
base_addr  in  DW  first memory address; latched on start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at sequence completion
rf_addr_rd  out  AW  register-file read address (cur_idx)
rf_rd_data  in  DW  register-file combinational read data
rf_addr_wr  out  AW  register-file write address
rf_wr_data  out  DW  register-file write data
rf_regw  out  1  register-file write enable, one cycle per LM register
mem_req  out  1  memory access request, held until acknowledged
mem_we  out  1  1 = write (SM), 0 = read (LM); valid with mem_req
mem_addr  out  DW  memory address
mem_wdata  out  DW  store data (= rf_rd_data during SM access)
mem_rdata  in  DW  load data, valid in the cycle mem_ack is high
mem_ack  in  1  access complete; sampled at rising edge while mem_req = 1

Behaviour:
- Reset (reset = 0, async):
  - State = IDLE; mask, pointer, cur_idx and load-data registers cleared.
  - All outputs 0.
  - Any in-flight access is abandoned: no rf_regw and no done pulse is produced.
- States: IDLE, SCAN, MEM, WB, DONE.
- IDLE:
  - If start = 1, latch op_lm, imm_mask, base_addr (ptr = base_addr), go to SCAN.
  - start while busy is ignored.
- SCAN:
  - Mask == 0 -> DONE.
  - Otherwise cur_idx = index of lowest set bit, clear that bit, go to MEM.
- MEM:
  - mem_req = 1, mem_addr = ptr, mem_we = ~op_lm.
  - rf_addr_rd = cur_idx, mem_wdata = rf_rd_data.
  - Held stable every cycle until mem_ack = 1 at an edge.
  - On ack, SM: ptr = ptr + 1, go to SCAN.
  - On ack, LM: capture mem_rdata, go to WB.
  - mem_ack while mem_req = 0 is ignored.
- WB (LM only):
  - rf_regw = 1 for exactly one cycle, rf_addr_wr = cur_idx, rf_wr_data = captured data.
  - ptr = ptr + 1, go to SCAN.
- DONE: done = 1 for one cycle, then IDLE. busy falls in the same edge done falls.
- Outputs are combinational decodes of registered state; rf_regw and mem_req are never high in the same cycle.
- ptr arithmetic is modulo 2^DW: 0xFFFF + 1 = 0x0000.
- Writing R7 (PC) in LM is permitted and performed like any other register; PC ownership is the main FSM's concern.
- Latency with k selected registers and mem_ack returned in the first MEM cycle (cycle 1 = first cycle after the start edge):
  - SM: done in cycle 2k+2.
  - LM: done in cycle 3k+2.
  - Empty mask: done in cycle 2 with no memory or register activity.
  - Each extra wait cycle on mem_ack adds one cycle.

Test Plan:
- SM, mask 0x05, base 0x0100, R0=0x1111, R2=0x2222, ack immediate:
  - Writes 0x1111 @0x0100 then 0x2222 @0x0101; mem_we=1 on both.
  - rf_regw never asserted; done in cycle 6.
- LM, mask 0x82, base 0x0200, memory 0x0200=0xAAAA, 0x0201=0xBBBB:
  - R1 <= 0xAAAA, then R7 <= 0xBBBB; rf_regw pulses exactly twice.
  - done in cycle 8.
- Empty mask (start, imm_mask=0x00):
  - No mem_req, no rf_regw; done pulses in cycle 2; busy high cycles 1-2.
- LM mask 0x01, mem_ack delayed 3 cycles:
  - mem_req/mem_addr held stable for 4 cycles; R0 written once; done in cycle 8.
- SM mask 0x03, base 0xFFFF:
  - Addresses 0xFFFF then 0x0000; start re-pulsed mid-sequence is ignored (mask/base unchanged).
- LM mask 0xFF, reset low asserted during third MEM cycle:
  - Outputs 0 immediately; no further rf_regw and no done.
  - After release, a new start with mask 0x01 completes normally.

Source files
------------

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks a register mask from the lowest
// set bit upward, moving one register per memory access at consecutive addresses.
module lm_sm_sequencer #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            op_lm,
    input  logic [NREG-1:0] imm_mask,
    input  logic [DW-1:0]   base_addr,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   rf_addr_rd,
    input  logic [DW-1:0]   rf_rd_data,
    output logic [AW-1:0]   rf_addr_wr,
    output logic [DW-1:0]   rf_wr_data,
    output logic            rf_regw,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            op_lm_q;
    logic [NREG-1:0] mask_q;
    logic [DW-1:0]   ptr_q;
    logic [AW-1:0]   cur_idx_q;
    logic [DW-1:0]   ld_data_q;
    logic [AW-1:0]   low_idx_d;

    // Descending scan so the lowest set bit is the one that sticks.
    always_comb begin
        low_idx_d = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx_d = AW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_lm_q   <= 1'b0;
            mask_q    <= '0;
            ptr_q     <= '0;
            cur_idx_q <= '0;
            ld_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_lm_q <= op_lm;
                        mask_q  <= imm_mask;
                        ptr_q   <= base_addr;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (mask_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        cur_idx_q <= low_idx_d;
                        mask_q    <= mask_q & (mask_q - NREG'(1));
                        state_q   <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op_lm_q) begin
                            ld_data_q <= mem_rdata;
                            state_q   <= S_WB;
                        end else begin
                            ptr_q   <= ptr_q + DW'(1);
                            state_q <= S_SCAN;
                        end
                    end
                end
                S_WB: begin
                    ptr_q   <= ptr_q + DW'(1);
                    state_q <= S_SCAN;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Data outputs are gated by state so nothing leaks out outside the owning cycle.
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign mem_req    = (state_q == S_MEM);
    assign mem_we     = mem_req & ~op_lm_q;
    assign mem_addr   = mem_req ? ptr_q : '0;
    assign mem_wdata  = mem_we ? rf_rd_data : '0;
    assign rf_addr_rd = cur_idx_q;
    assign rf_regw    = (state_q == S_WB);
    assign rf_addr_wr = rf_regw ? cur_idx_q : '0;
    assign rf_wr_data = rf_regw ? ld_data_q : '0;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Randomized bench for lm_sm_sequencer: a register-file and memory model drive the
// DUT, and expected transfers and completion cycles are computed up front per sequence.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op_lm = 1'b0;
    logic [7:0]  imm_mask = '0;
    logic [15:0] base_addr = '0;
    logic        busy, done;
    logic [2:0]  rf_addr_rd, rf_addr_wr;
    logic [15:0] rf_rd_data, rf_wr_data;
    logic        rf_regw, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic [15:0] regs_m [8];
    logic [15:0] mem_m [65536];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rf_rd_data = regs_m[rf_addr_rd];

    lm_sm_sequencer #(.NREG(8), .AW(3), .DW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_lm      (op_lm),
        .imm_mask   (imm_mask),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .rf_addr_rd (rf_addr_rd),
        .rf_rd_data (rf_rd_data),
        .rf_addr_wr (rf_addr_wr),
        .rf_wr_data (rf_wr_data),
        .rf_regw    (rf_regw),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_mem_req"}, mem_req, 0);
        check_eq({tag, "_mem_we"}, mem_we, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
        check_eq({tag, "_rf_regw"}, rf_regw, 0);
        check_eq({tag, "_rf_addr_wr"}, rf_addr_wr, 0);
        check_eq({tag, "_rf_wr_data"}, rf_wr_data, 0);
        check_eq({tag, "_rf_addr_rd"}, rf_addr_rd, 0);
    endtask

    // wfix < 0 picks a random ack delay per transfer; repulse re-asserts start while busy.
    task automatic run_seq(input logic op, input logic [7:0] mask, input logic [15:0] base,
                           input int wfix, input bit repulse);
        int          idxq [$];
        logic [15:0] expd [$];
        int          waits [$];
        int          k, exp_done, c, n, wb_n, wleft;
        bit          in_mem;
        logic [15:0] a;

        for (int i = 0; i < 8; i++) begin
            if (mask[i]) idxq.push_back(i);
        end
        k = idxq.size();
        exp_done = 2;
        for (int j = 0; j < k; j++) begin
            a = base + 16'(j);
            waits.push_back(wfix < 0 ? int'($urandom_range(0, 3)) : wfix);
            exp_done += (op ? 3 : 2) + waits[j];
            expd.push_back(op ? mem_m[a] : regs_m[idxq[j]]);
        end

        @(negedge clk);
        start = 1'b1; op_lm = op; imm_mask = mask; base_addr = base; mem_ack = 1'b0;
        @(posedge clk);
        c = 0; n = 0; wb_n = 0; wleft = 0; in_mem = 1'b0;
        while (1) begin
            @(negedge clk);
            c++;
            mem_ack = 1'b0;
            start = 1'b0;
            if (repulse && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                op_lm = 1'($urandom);
                imm_mask = 8'($urandom);
                base_addr = 16'($urandom);
            end
            check_eq("busy", busy, 1);
            check_eq("excl", mem_req & rf_regw, 0);
            if (mem_req) begin
                if (n >= k) begin
                    check_eq("extra_req", n, k);
                end else begin
                    a = base + 16'(n);
                    check_eq("mem_addr", mem_addr, a);
                    check_eq("mem_we", mem_we, !op);
                    if (!op) check_eq("mem_wdata", mem_wdata, expd[n]);
                    if (!in_mem) begin
                        in_mem = 1'b1;
                        wleft = waits[n];
                    end
                    if (wleft == 0) begin
                        mem_ack = 1'b1;
                        if (op) begin
                            mem_rdata = mem_m[a];
                        end else begin
                            mem_rdata = 16'($urandom);
                            mem_m[a] = mem_wdata;
                        end
                        in_mem = 1'b0;
                        n++;
                    end else begin
                        wleft--;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
                mem_rdata = 16'($urandom);
            end
            if (rf_regw) begin
                if (!op || wb_n >= k) begin
                    check_eq("extra_regw", rf_regw, 0);
                end else begin
                    check_eq("rf_addr_wr", rf_addr_wr, idxq[wb_n]);
                    check_eq("rf_wr_data", rf_wr_data, expd[wb_n]);
                    regs_m[rf_addr_wr] = rf_wr_data;
                    wb_n++;
                end
            end
            if (done) begin
                check_eq("done_cycle", c, exp_done);
                check_eq("xfers", n, k);
                check_eq("wbs", wb_n, op ? k : 0);
                start = 1'b0;
                break;
            end
            if (c > exp_done + 50) begin
                check_eq("timeout", c, exp_done);
                start = 1'b0;
                break;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("busy_after", busy, 0);
        check_eq("done_after", done, 0);
        $display("seq op=%0s mask=%02h base=%04h k=%0d done_cycle=%0d expected=%0d",
                 op ? "LM" : "SM", mask, base, k, c, exp_done);
    endtask

    task automatic reset_mid_lm();
        int cnt;
        int guard;
        @(negedge clk);
        start = 1'b1; op_lm = 1'b1; imm_mask = 8'hFF; base_addr = 16'($urandom);
        @(posedge clk);
        cnt = 0;
        guard = 0;
        while (cnt < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            mem_ack = 1'b0;
            if (rf_regw) regs_m[rf_addr_wr] = rf_wr_data;
            if (mem_req) begin
                cnt++;
                if (cnt < 3) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_m[mem_addr];
                end
            end
        end
        check_eq("rst_reach_mem3", cnt, 3);
        reset = 1'b0;
        #1;
        check_all_zero("rst_async");
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check_eq("rst_hold_regw", rf_regw, 0);
            check_eq("rst_hold_done", done, 0);
            check_eq("rst_hold_busy", busy, 0);
        end
        reset = 1'b1;
        $display("seq op=LM mask=ff reset asserted in third MEM cycle");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_m[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) regs_m[i] = 16'($urandom);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        regs_m[0] = 16'h1111;
        regs_m[2] = 16'h2222;
        run_seq(1'b0, 8'h05, 16'h0100, 0, 1'b0);
        check_eq("sm_mem0100", mem_m[16'h0100], 16'h1111);
        check_eq("sm_mem0101", mem_m[16'h0101], 16'h2222);

        mem_m[16'h0200] = 16'hAAAA;
        mem_m[16'h0201] = 16'hBBBB;
        run_seq(1'b1, 8'h82, 16'h0200, 0, 1'b0);
        check_eq("lm_r1", regs_m[1], 16'hAAAA);
        check_eq("lm_r7", regs_m[7], 16'hBBBB);

        run_seq(1'b0, 8'h00, 16'h1234, 0, 1'b0);
        run_seq(1'b1, 8'h00, 16'h4321, 0, 1'b1);
        run_seq(1'b1, 8'h01, 16'h0300, 3, 1'b0);
        run_seq(1'b0, 8'h03, 16'hFFFF, 0, 1'b1);

        reset_mid_lm();
        run_seq(1'b1, 8'h01, 16'($urandom), 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_seq(1'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                    16'($urandom), -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
